// File: rtl/dbg_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : dbg_run_ctrl_if
// Brief   : Debug command channel (valid/ready, opcode, index, data).
// Revision: 1.0
// ============================================================================
interface dbg_run_ctrl_if #(
    parameter int PC_W  = 32,
    parameter int IDX_W = 2
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [IDX_W-1:0] cmd_idx;
    logic [PC_W-1:0]  cmd_data;

    modport master (output cmd_valid, cmd_op, cmd_idx, cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_idx, cmd_data, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/dbg_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dbg_run_ctrl
// Brief   : CPU run/step/breakpoint controller; optional PC trace buffer
//           enabled with macro DBG_TRACE_EN.
// Revision: 1.0
// ============================================================================
module dbg_run_ctrl #(
    parameter int NUM_BP      = 4,
    parameter int PC_W        = 32,
    parameter int STEP_W      = 16,
    parameter int TRACE_DEPTH = 16,
    localparam int IDX_W      = (NUM_BP > 1) ? $clog2(NUM_BP) : 1,
    localparam int CNT_W      = $clog2(TRACE_DEPTH) + 1
) (
    input  wire logic               clk,
    input  wire logic               rstn,
    dbg_run_ctrl_if.slave           cmd,
    input  wire logic [PC_W-1:0]    pc_chk,
    output logic                    cpu_ce,
    output logic                    halted,
    output logic                    hit_valid,
    output logic [IDX_W-1:0]        hit_idx,
    output logic [STEP_W-1:0]       step_left,
    input  wire logic               trace_rd,
    output logic [PC_W-1:0]         trace_data,
    output logic                    trace_empty,
    output logic [CNT_W-1:0]        trace_cnt
);
    typedef enum logic [1:0] {S_HALT = 2'd0, S_STEP = 2'd1, S_RUN = 2'd2} state_t;

    localparam logic [2:0] c_op_set_bp  = 3'd1;
    localparam logic [2:0] c_op_clr_bp  = 3'd2;
    localparam logic [2:0] c_op_step    = 3'd3;
    localparam logic [2:0] c_op_run     = 3'd4;
    localparam logic [2:0] c_op_halt    = 3'd5;
    localparam logic [2:0] c_op_clr_all = 3'd6;

    state_t                r_state, w_state_nxt;
    logic [STEP_W-1:0]     r_step_left, w_step_nxt;
    logic                  r_skip, w_skip_nxt;
    logic                  r_hit_valid, w_hit_nxt;
    logic [IDX_W-1:0]      r_hit_idx, w_hit_idx_nxt;
    logic [NUM_BP-1:0]     r_bp_en;
    logic [PC_W-1:0]       r_bp_addr [NUM_BP];
    logic                  w_match;
    logic [IDX_W-1:0]      w_match_idx;
    logic                  w_cmd_acc;
    logic                  w_idx_ok;
    logic [STEP_W-1:0]     w_step_cnt;

    // Run-type commands stall until the CPU is parked in HALT.
    assign cmd.cmd_ready = !(((cmd.cmd_op == c_op_step) || (cmd.cmd_op == c_op_run))
                             && (r_state != S_HALT));
    assign w_cmd_acc  = cmd.cmd_valid && cmd.cmd_ready;
    assign w_idx_ok   = ({1'b0, cmd.cmd_idx} < (IDX_W+1)'(NUM_BP));
    assign w_step_cnt = cmd.cmd_data[STEP_W-1:0];

    // Descending scan so the lowest matching index wins.
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (r_bp_en[i] && (r_bp_addr[i] == pc_chk)) begin
                w_match     = 1'b1;
                w_match_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_step_nxt    = r_step_left;
        w_skip_nxt    = r_skip;
        w_hit_nxt     = 1'b0;
        w_hit_idx_nxt = r_hit_idx;
        cpu_ce        = 1'b0;
        case (r_state)
            S_STEP: begin
                cpu_ce = 1'b1;
                if (r_step_left <= STEP_W'(1)) begin
                    w_state_nxt = S_HALT;
                    w_step_nxt  = '0;
                end else begin
                    w_step_nxt  = r_step_left - STEP_W'(1);
                end
            end
            S_RUN: begin
                w_skip_nxt = 1'b0;
                if (w_match && !r_skip) begin
                    w_state_nxt   = S_HALT;
                    w_hit_nxt     = 1'b1;
                    w_hit_idx_nxt = w_match_idx;
                end else begin
                    cpu_ce = 1'b1;
                end
            end
            default: cpu_ce = 1'b0;
        endcase
        if (w_cmd_acc) begin
            case (cmd.cmd_op)
                c_op_step: begin
                    w_state_nxt = S_STEP;
                    w_step_nxt  = (w_step_cnt == '0) ? STEP_W'(1) : w_step_cnt;
                end
                c_op_run: begin
                    w_state_nxt = S_RUN;
                    w_skip_nxt  = 1'b1;
                end
                c_op_halt: begin
                    w_state_nxt = S_HALT;
                    w_step_nxt  = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_HALT;
            r_step_left <= '0;
            r_skip      <= 1'b0;
            r_hit_valid <= 1'b0;
            r_hit_idx   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_step_left <= w_step_nxt;
            r_skip      <= w_skip_nxt;
            r_hit_valid <= w_hit_nxt;
            r_hit_idx   <= w_hit_idx_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bp_en   <= '0;
            r_bp_addr <= '{default: '0};
        end else if (w_cmd_acc) begin
            case (cmd.cmd_op)
                c_op_set_bp: if (w_idx_ok) begin
                    r_bp_en[cmd.cmd_idx]   <= 1'b1;
                    r_bp_addr[cmd.cmd_idx] <= cmd.cmd_data;
                end
                c_op_clr_bp: if (w_idx_ok) r_bp_en[cmd.cmd_idx] <= 1'b0;
                c_op_clr_all: r_bp_en <= '0;
                default: ;
            endcase
        end
    end

    assign halted    = (r_state == S_HALT);
    assign hit_valid = r_hit_valid;
    assign hit_idx   = r_hit_idx;
    assign step_left = r_step_left;

`ifdef DBG_TRACE_EN
    localparam int PTR_W = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;

    logic [PC_W-1:0]  r_trace_mem [TRACE_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             w_full, w_empty, w_wr, w_rd;

    assign w_full  = (r_cnt == CNT_W'(TRACE_DEPTH));
    assign w_empty = (r_cnt == '0);
    assign w_wr    = cpu_ce;
    assign w_rd    = trace_rd && !w_empty;

    // A write into a full buffer drops the oldest entry by advancing the read side.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_rd || (w_wr && w_full)) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_wr && !w_rd && !w_full) r_cnt <= r_cnt + CNT_W'(1);
            else if (w_rd && !w_wr)       r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_trace_mem[r_wr_ptr] <= pc_chk;
    end

    assign trace_data  = w_empty ? '0 : r_trace_mem[r_rd_ptr];
    assign trace_empty = w_empty;
    assign trace_cnt   = r_cnt;
`else
    logic unused_trace_rd;
    assign unused_trace_rd = trace_rd;
    assign trace_data      = '0;
    assign trace_empty     = 1'b1;
    assign trace_cnt       = '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_dbg_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dbg_run_ctrl
// Brief   : Scoreboard bench for dbg_run_ctrl (executed-PC and hit queues).
// Revision: 1.0
// ============================================================================
module tb_dbg_run_ctrl;
    localparam int PC_W = 32, NUM_BP = 4, IDX_W = 2, STEP_W = 16, TD = 4, CNT_W = 3;
    localparam logic [2:0] OP_SET = 3'd1, OP_CLR = 3'd2, OP_STEP = 3'd3,
                           OP_RUN = 3'd4, OP_HALT = 3'd5;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    dbg_run_ctrl_if #(.PC_W(PC_W), .IDX_W(IDX_W)) cmd_if ();

    logic [PC_W-1:0]   pc = '0;
    logic              pc_load = 1'b0;
    logic [PC_W-1:0]   pc_load_val = '0;
    logic              cpu_ce, halted, hit_valid, trace_empty;
    logic [IDX_W-1:0]  hit_idx;
    logic [STEP_W-1:0] step_left;
    logic              trace_rd = 1'b0;
    logic [PC_W-1:0]   trace_data;
    logic [CNT_W-1:0]  trace_cnt;

    dbg_run_ctrl #(.NUM_BP(NUM_BP), .PC_W(PC_W), .STEP_W(STEP_W), .TRACE_DEPTH(TD)) dut (
        .clk(clk), .rstn(rstn), .cmd(cmd_if), .pc_chk(pc), .cpu_ce(cpu_ce),
        .halted(halted), .hit_valid(hit_valid), .hit_idx(hit_idx), .step_left(step_left),
        .trace_rd(trace_rd), .trace_data(trace_data), .trace_empty(trace_empty),
        .trace_cnt(trace_cnt)
    );

    // CPU model: PC advances by one instruction on every enabled clock.
    always @(posedge clk) begin
        if (pc_load)     pc <= pc_load_val;
        else if (cpu_ce) pc <= pc + 32'd4;
    end

    int checks = 0;
    int errors = 0;
    logic [PC_W-1:0]  exp_pc  [$];
    logic [IDX_W-1:0] exp_hit [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cpu_ce === 1'b1) begin
            if (exp_pc.size() == 0) begin
                checks++; errors++;
                $display("FAIL pc_exec_extra actual=0x%0h expected=none", pc);
            end else chk("pc_exec", pc, exp_pc.pop_front());
        end
        if (hit_valid === 1'b1) begin
            if (exp_hit.size() == 0) begin
                checks++; errors++;
                $display("FAIL hit_extra actual=%0d expected=none", hit_idx);
            end else chk("hit_idx", 32'(hit_idx), 32'(exp_hit.pop_front()));
        end
    end

    task automatic push_pcs(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_pc.push_back(start + 32'(4 * i));
    endtask

    task automatic load_pc(input logic [31:0] v);
        pc_load = 1'b1; pc_load_val = v;
        @(posedge clk); #1;
        pc_load = 1'b0;
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [IDX_W-1:0] idx, input logic [31:0] data);
        int n = 0;
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = op; cmd_if.cmd_idx = idx; cmd_if.cmd_data = data;
        @(negedge clk);
        while (!cmd_if.cmd_ready && n < 100) begin n++; @(negedge clk); end
        if (!cmd_if.cmd_ready) begin
            checks++; errors++;
            $display("FAIL cmd_accept_timeout actual=0 expected=1 op=%0d", op);
        end
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = 3'd0;
    endtask

    task automatic wait_halted();
        int n = 0;
        @(negedge clk);
        while (!halted && n < 200) begin n++; @(negedge clk); end
        chk("halt_reached", 32'(halted), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = 3'd0; cmd_if.cmd_idx = '0; cmd_if.cmd_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_cpu_ce", 32'(cpu_ce), 32'd0);
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_hit_valid", 32'(hit_valid), 32'd0);
        chk("rst_hit_idx", 32'(hit_idx), 32'd0);
        chk("rst_step_left", 32'(step_left), 32'd0);
        chk("rst_trace_cnt", 32'(trace_cnt), 32'd0);
        chk("rst_trace_empty", 32'(trace_empty), 32'd1);
        chk("rst_trace_data", trace_data, 32'd0);
        chk("rst_cmd_ready", 32'(cmd_if.cmd_ready), 32'd1);
        @(posedge clk); #1;
        rstn = 1'b1;

`ifdef DBG_TRACE_EN
        load_pc(32'h0);
        push_pcs(32'h0, 6);
        send_cmd(OP_STEP, 0, 32'd6);
        wait_halted();
        chk("trace_cnt_full", 32'(trace_cnt), 32'd4);
        chk("trace_not_empty", 32'(trace_empty), 32'd0);
        trace_rd = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("trace_pop", trace_data, 32'h8 + 32'(4 * k));
            @(posedge clk); #1;
        end
        trace_rd = 1'b0;
        @(negedge clk);
        chk("trace_empty_after", 32'(trace_empty), 32'd1);
        chk("trace_cnt_after", 32'(trace_cnt), 32'd0);
        @(posedge clk); #1;
`endif

        // STEP 3: three enabled cycles, countdown visible, halted afterwards
        load_pc(32'h100);
        push_pcs(32'h100, 3);
        send_cmd(OP_STEP, 0, 32'd3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("step_left", 32'(step_left), 32'(3 - k));
            chk("step_halted", 32'(halted), (k == 3) ? 32'd1 : 32'd0);
        end
        @(posedge clk); #1;
        push_pcs(32'h10C, 1);
        send_cmd(OP_STEP, 0, 32'd0);
        wait_halted();
        chk("step0_left", 32'(step_left), 32'd0);

        // Breakpoint at 0x10 on idx1
        load_pc(32'h0);
        send_cmd(OP_SET, 2'd1, 32'h10);
        push_pcs(32'h0, 4);
        exp_hit.push_back(2'd1);
        send_cmd(OP_RUN, 0, 32'd0);
        wait_halted();
        chk("bp1_stop_pc", pc, 32'h10);

        // Resume past 0x10, stop at idx3
        send_cmd(OP_SET, 2'd3, 32'h20);
        push_pcs(32'h10, 4);
        exp_hit.push_back(2'd3);
        send_cmd(OP_RUN, 0, 32'd0);
        wait_halted();
        chk("bp3_stop_pc", pc, 32'h20);

        // idx1 cleared; idx0 and idx2 share 0x20, lowest wins
        send_cmd(OP_CLR, 2'd1, 32'd0);
        send_cmd(OP_CLR, 2'd3, 32'd0);
        send_cmd(OP_SET, 2'd0, 32'h20);
        send_cmd(OP_SET, 2'd2, 32'h20);
        load_pc(32'h8);
        push_pcs(32'h8, 6);
        exp_hit.push_back(2'd0);
        send_cmd(OP_RUN, 0, 32'd0);
        wait_halted();
        chk("bp0_stop_pc", pc, 32'h20);
        chk("hit_idx_held", 32'(hit_idx), 32'd0);

        // Run/step commands stall while running; HALT stops it
        push_pcs(32'h20, 7);
        send_cmd(OP_RUN, 0, 32'd0);
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = OP_STEP; cmd_if.cmd_data = 32'd5;
        for (int j = 0; j < 6; j++) begin
            if (j == 3) cmd_if.cmd_op = OP_RUN;
            @(negedge clk);
            chk("stall_ready", 32'(cmd_if.cmd_ready), 32'd0);
            @(posedge clk); #1;
        end
        send_cmd(OP_HALT, 0, 32'd0);
        @(negedge clk);
        chk("halt_cmd_halted", 32'(halted), 32'd1);
        chk("halt_cmd_step", 32'(step_left), 32'd0);
        @(posedge clk); #1;

        // HALT during a long STEP
        push_pcs(32'h3C, 1);
        send_cmd(OP_STEP, 0, 32'd10);
        send_cmd(OP_HALT, 0, 32'd0);
        @(negedge clk);
        chk("step_abort_left", 32'(step_left), 32'd0);
        chk("step_abort_halted", 32'(halted), 32'd1);
        @(posedge clk); #1;

        // Asynchronous reset mid-RUN clears breakpoints
        load_pc(32'h0);
        push_pcs(32'h0, 2);
        send_cmd(OP_RUN, 0, 32'd0);
        repeat (2) begin @(posedge clk); #1; end
        rstn = 1'b0;
        #1;
        chk("async_rst_ce", 32'(cpu_ce), 32'd0);
        chk("async_rst_halted", 32'(halted), 32'd1);
        @(posedge clk); #1;
        rstn = 1'b1;
        load_pc(32'h0);
        push_pcs(32'h0, 9);
        send_cmd(OP_RUN, 0, 32'd0);
        repeat (8) begin @(posedge clk); #1; end
        send_cmd(OP_HALT, 0, 32'd0);

`ifndef DBG_TRACE_EN
        trace_rd = 1'b1;
        @(negedge clk);
        chk("notrace_cnt", 32'(trace_cnt), 32'd0);
        chk("notrace_empty", 32'(trace_empty), 32'd1);
        chk("notrace_data", trace_data, 32'd0);
        @(posedge clk); #1;
        trace_rd = 1'b0;
`endif

        repeat (3) @(negedge clk);
        chk("pc_queue_left", 32'(exp_pc.size()), 32'd0);
        chk("hit_queue_left", 32'(exp_hit.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dbg_run_ctrl.md
# dbg_run_ctrl

Parametrised run/step/breakpoint controller for the pipelined CPU debug path. It owns the CPU clock-enable and holds NUM_BP hardware PC breakpoints compared against the EX-stage PC (pce). It executes step-N, run-to-breakpoint and halt commands from the serial debug front end. An optional circular trace buffer records every PC the CPU advances through.

## Interface
- NUM_BP, default 4: number of breakpoint comparators (1..16).
- PC_W, default 32: PC width.
- STEP_W, default 16: step counter width.
- TRACE_DEPTH, default 16: trace entries, power of two (used only with DBG_TRACE_EN).
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when both high.
- cmd_op  in  3  0 NOP, 1 SET_BP, 2 CLR_BP, 3 STEP, 4 RUN, 5 HALT, 6 CLR_ALL; 7 treated as NOP.
- cmd_idx  in  $clog2(NUM_BP) (min 1)  breakpoint index for SET_BP/CLR_BP.
- cmd_data  in  PC_W  breakpoint address (SET_BP) or step count (STEP, low STEP_W bits).
- pc_chk  in  PC_W  EX-stage PC from the CPU.
- cpu_ce  out  1  CPU clock enable.
- halted  out  1  controller in HALT.
- hit_valid  out  1  one-cycle pulse on breakpoint stop.
- hit_idx  out  $clog2(NUM_BP)  index of the breakpoint that stopped the CPU.
- step_left  out  STEP_W  remaining steps.
- trace_rd  in  1  pop oldest trace entry.
- trace_data  out  PC_W  oldest trace entry (show-ahead).
- trace_empty  out  1  trace buffer empty.
- trace_cnt  out  $clog2(TRACE_DEPTH)+1  valid entries.

## Operation
- States: HALT, STEP, RUN. Reset state is HALT.
- match = OR over i of (bp_en[i] && bp_addr[i]==pc_chk). Match index is the lowest matching i.
- cpu_ce is combinational:
  - STEP: 1.
  - RUN: 1 unless (match && !skip).
  - HALT: 0.
- cmd_ready = 0 only when cmd_op is STEP or RUN and the state is not HALT (stall until halted). Otherwise cmd_ready = 1.
- SET_BP: bp_addr[idx] <= cmd_data and bp_en[idx] <= 1. CLR_BP: bp_en[idx] <= 0. CLR_ALL: all bp_en <= 0. All three are legal in any state and take effect on the next compare cycle.
- STEP: step_left <= (count==0 ? 1 : count), go to STEP.
  - Each cycle in STEP, step_left decrements.
  - When step_left==1, the next state is HALT and step_left becomes 0.
  - Breakpoints are ignored in STEP.
- RUN: go to RUN with skip <= 1. skip clears after the first RUN cycle, so resuming from a breakpoint PC executes past it.
- In RUN, when match && !skip: cpu_ce = 0 that cycle, next state HALT, hit_valid = 1 next cycle, hit_idx latched.
- HALT command: next state HALT from any state and step_left <= 0. The CPU still advances in the acceptance cycle if cpu_ce was 1.
- Simultaneous breakpoint stop and accepted HALT: HALT is reached and hit_valid still pulses.

## Timing
- Reset values: state HALT, cpu_ce 0, halted 1, hit_valid 0, hit_idx 0, step_left 0, all bp_en 0, bp_addr 0, skip 0, trace empty (trace_cnt 0, trace_data 0).
- Reset asserted mid-RUN/STEP forces HALT immediately (asynchronous). Breakpoints and trace are lost.
- Command-to-effect latency: 1 clk. A STEP of N yields exactly N cycles of cpu_ce=1, starting the cycle after acceptance.
- Breakpoint stop latency: 0 cycles. The CPU never advances with a matching pc_chk in RUN (except the skip cycle).
- halted is registered state. It is high in the cycle after the last cpu_ce pulse.

## Configuration
- DBG_TRACE_EN defined: a TRACE_DEPTH circular buffer writes pc_chk every cycle cpu_ce=1.
  - When full, a write overwrites the oldest entry; trace_cnt stays TRACE_DEPTH.
  - trace_rd when empty is ignored.
  - Write and read in the same cycle: count unchanged if non-empty. If empty, the write is kept and the read is ignored.
- DBG_TRACE_EN undefined: no storage. trace_data = 0, trace_cnt = 0, trace_empty = 1, trace_rd ignored. Ports remain.

## Test plan
- Reset, then STEP count 3 -> cpu_ce high exactly 3 cycles, step_left 3,2,1,0, halted after; STEP count 0 -> exactly 1 cycle.
- SET_BP idx1 addr 0x0000_0010, RUN with pc_chk ramping 0x0,0x4,... -> cpu_ce low in the cycle pc_chk=0x10, hit_valid pulse, hit_idx=1, halted.
- From that stop, RUN again -> pc_chk 0x10 passes (skip), CPU continues. CLR_BP idx1 -> no further stop at 0x10.
- Breakpoints idx0 and idx2 both 0x20 -> stop with hit_idx=0. STEP/RUN issued while RUN -> cmd_ready 0 until HALT accepted.
- Deassert rstn mid-RUN -> cpu_ce 0 and halted 1 immediately. All bp_en cleared, so a subsequent RUN never stops.
- DBG_TRACE_EN, TRACE_DEPTH 4, STEP 6 through 0x0..0x14 -> trace_cnt 4, pops return 0x8,0xC,0x10,0x14, then trace_empty 1.
